// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and fetch state encoding
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RV_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: aligned next fetch address and misalign flag from the consumed instruction
module pc_next
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);
  // taken redirects drop the low address bits; sequential flow wraps at 2^32
  always_comb begin
    next_pc_o  = br_taken_i ? {br_target_i[XLEN-1:2], 2'b00} : pc_i + 32'd4;
    misalign_o = br_taken_i & (|br_target_i[1:0]);
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I program counter and single-outstanding instruction memory fetch
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RV_RESET_PC,
  parameter logic [ILEN-1:0] NOP_INSTR = RV_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_gnt,
  input  logic            im_rvalid,
  input  logic [ILEN-1:0] im_rdata,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            core_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            misalign
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, pc_q, pc_d, nxt_pc;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            mis_q, mis_d, nxt_mis;

  pc_next u_pc_next (
    .pc_i       (pc_q),
    .br_taken_i (br_taken),
    .br_target_i(br_target),
    .next_pc_o  (nxt_pc),
    .misalign_o (nxt_mis)
  );

  // next state: grant and response only matter in REQ and WAIT, so stale pulses are dropped
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = REQ;
        addr_d  = RESET_PC;
      end
      REQ: state_d = im_gnt ? WAIT : REQ;
      WAIT: if (im_rvalid) begin
        state_d = HOLD;
        instr_d = im_rdata;
        pc_d    = addr_q;
      end
      HOLD: if (core_ready) begin
        state_d = REQ;
        addr_d  = nxt_pc;
        instr_d = NOP_INSTR;
        mis_d   = nxt_mis;
      end
      default: state_d = BOOT;
    endcase
  end

  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  assign im_req      = (state_q == REQ);
  assign im_addr     = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign misalign    = mis_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a grant/latency memory model
module tb_instr_fetch;
  import rv32i_pkg::*;

  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic im_req, im_gnt, im_rvalid, instr_valid, misalign;
  logic [31:0] im_addr, im_rdata, instr, instr_pc;
  logic core_ready = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = '0;

  logic auto = 1'b0, ovr_en = 1'b0;
  logic [31:0] ovr = '0;
  int gnt_delay = 0;
  logic a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  exp_t sb[$];
  exp_t cur;
  int checks = 0, fails = 0;

  assign im_gnt    = auto ? a_gnt : m_gnt;
  assign im_rvalid = auto ? a_rvalid : m_rvalid;
  assign im_rdata  = auto ? a_rdata : m_rdata;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .core_ready(core_ready), .br_taken(br_taken),
    .br_target(br_target), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_0013;
  endfunction

  // memory model: grant after gnt_delay request cycles, respond one cycle after grant
  initial begin
    int pend, gnt_wait;
    logic [31:0] pdata;
    pend = -1; gnt_wait = 0; pdata = '0;
    a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
    forever begin
      @(negedge clk);
      a_gnt = 1'b0; a_rvalid = 1'b0;
      if (!auto) begin
        pend = -1; gnt_wait = 0;
      end else begin
        if (pend == 0) begin a_rvalid = 1'b1; a_rdata = pdata; end
        if (pend >= 0) pend--;
        if (im_req && pend < 0) begin
          if (gnt_wait >= gnt_delay) begin
            a_gnt = 1'b1; gnt_wait = 0; pend = 0;
            pdata = ovr_en ? ovr : mem_word(im_addr);
            sb.push_back('{im_addr, pdata});
          end else gnt_wait++;
        end
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (instr_valid !== 1'b1 && n < 50);
  endtask

  task automatic take(output bit ok);
    ok = (sb.size() != 0) && (instr_valid === 1'b1);
    if (sb.size() != 0) cur = sb.pop_front();
    else cur = '{32'hxxxx_xxxx, 32'hxxxx_xxxx};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (im_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", im_req); end
    if (im_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", im_addr); end
    if (instr !== 32'h13) begin fails++; $display("FAIL rst_instr got %h exp 00000013", instr); end
    if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", instr_pc); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    if (misalign !== 1'b0) begin fails++; $display("FAIL rst_mis got %b exp 0", misalign); end
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (im_req !== 1'b1) begin fails++; $display("FAIL boot_req got %b exp 1", im_req); end
    if (im_addr !== 32'h0) begin fails++; $display("FAIL boot_addr got %h exp 0", im_addr); end
  endtask

  task automatic test_stream;
    int n;
    bit ok;
    gnt_delay = 0; auto = 1'b1; core_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      take(ok);
      if (i == 2) core_ready = 1'b0;
      checks += 4;
      if (!ok) begin fails++; $display("FAIL stream_valid%0d got valid=%b queue=%0d exp 1", i, instr_valid, sb.size()); end
      if (instr !== cur.data) begin fails++; $display("FAIL stream_instr%0d got %h exp %h", i, instr, cur.data); end
      if (instr_pc !== 32'(4 * i)) begin fails++; $display("FAIL stream_pc%0d got %h exp %h", i, instr_pc, 32'(4 * i)); end
      if (i > 0 && n != 3) begin fails++; $display("FAIL stream_lat%0d got %0d exp 3", i, n); end
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks += 4;
      if (instr !== cur.data) begin fails++; $display("FAIL hold_instr%0d got %h exp %h", i, instr, cur.data); end
      if (instr_pc !== 32'h8) begin fails++; $display("FAIL hold_pc%0d got %h exp 00000008", i, instr_pc); end
      if (instr_valid !== 1'b1) begin fails++; $display("FAIL hold_valid%0d got %b exp 1", i, instr_valid); end
      if (im_req !== 1'b0) begin fails++; $display("FAIL hold_req%0d got %b exp 0", i, im_req); end
    end
  endtask

  task automatic test_grant_stall;
    int n;
    bit ok;
    gnt_delay = 4; ovr_en = 1'b1; ovr = 32'h0020_8133;
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks += 2;
      if (im_req !== 1'b1) begin fails++; $display("FAIL stall_req%0d got %b exp 1", k, im_req); end
      if (im_addr !== 32'hC) begin fails++; $display("FAIL stall_addr%0d got %h exp 0000000c", k, im_addr); end
    end
    wait_valid(n);
    take(ok);
    checks += 4;
    if (!ok) begin fails++; $display("FAIL stall_valid got %b exp 1", instr_valid); end
    if (n != 2) begin fails++; $display("FAIL stall_lat got %0d exp 2", n); end
    if (instr !== 32'h0020_8133) begin fails++; $display("FAIL stall_instr got %h exp 00208133", instr); end
    if (instr_pc !== 32'hC) begin fails++; $display("FAIL stall_pc got %h exp 0000000c", instr_pc); end
    gnt_delay = 0; ovr_en = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] tgt, input logic taken, input logic [31:0] exp_addr, input logic exp_mis);
    int n;
    bit ok;
    br_taken = taken; br_target = tgt; core_ready = 1'b1;
    @(negedge clk);
    br_taken = 1'b0; br_target = 32'h0; core_ready = 1'b0;
    checks += 3;
    if (misalign !== exp_mis) begin fails++; $display("FAIL br_mis(%h) got %b exp %b", tgt, misalign, exp_mis); end
    if (im_req !== 1'b1) begin fails++; $display("FAIL br_req(%h) got %b exp 1", tgt, im_req); end
    if (im_addr !== exp_addr) begin fails++; $display("FAIL br_addr(%h) got %h exp %h", tgt, im_addr, exp_addr); end
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0) begin fails++; $display("FAIL br_mis_pulse(%h) got %b exp 0", tgt, misalign); end
    wait_valid(n);
    take(ok);
    checks += 3;
    if (!ok) begin fails++; $display("FAIL br_valid(%h) got %b exp 1", tgt, instr_valid); end
    if (instr_pc !== exp_addr) begin fails++; $display("FAIL br_pc(%h) got %h exp %h", tgt, instr_pc, exp_addr); end
    if (instr !== cur.data) begin fails++; $display("FAIL br_instr(%h) got %h exp %h", tgt, instr, cur.data); end
  endtask

  task automatic test_branch;
    branch_to(32'h0000_0102, 1'b1, 32'h0000_0100, 1'b1);
    branch_to(32'h0000_0040, 1'b1, 32'h0000_0040, 1'b0);
  endtask

  task automatic test_wrap;
    branch_to(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0);
    branch_to(32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_stale_reset;
    int n;
    bit ok;
    auto = 1'b0; core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    checks += 2;
    if (im_req !== 1'b1) begin fails++; $display("FAIL stale_req got %b exp 1", im_req); end
    if (im_addr !== 32'h4) begin fails++; $display("FAIL stale_addr got %h exp 00000004", im_addr); end
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    checks += 3;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL stale_rst_valid got %b exp 0", instr_valid); end
    if (im_addr !== 32'h0) begin fails++; $display("FAIL stale_rst_addr got %h exp 0", im_addr); end
    if (instr !== 32'h13) begin fails++; $display("FAIL stale_rst_instr got %h exp 00000013", instr); end
    @(negedge clk);
    checks += 3;
    if (im_req !== 1'b1) begin fails++; $display("FAIL stale_boot_req got %b exp 1", im_req); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL stale_boot_valid got %b exp 0", instr_valid); end
    if (instr !== 32'h13) begin fails++; $display("FAIL stale_boot_instr got %h exp 00000013", instr); end
    @(negedge clk);
    m_rvalid = 1'b0;
    checks += 2;
    if (im_req !== 1'b1) begin fails++; $display("FAIL stale_req_hold got %b exp 1", im_req); end
    if (instr !== 32'h13) begin fails++; $display("FAIL stale_req_instr got %h exp 00000013", instr); end
    sb.delete();
    auto = 1'b1;
    wait_valid(n);
    take(ok);
    checks += 3;
    if (!ok) begin fails++; $display("FAIL stale_first_valid got %b exp 1", instr_valid); end
    if (instr_pc !== 32'h0) begin fails++; $display("FAIL stale_first_pc got %h exp 0", instr_pc); end
    if (instr !== mem_word(32'h0)) begin fails++; $display("FAIL stale_first_instr got %h exp %h", instr, mem_word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_grant_stall();
    test_branch();
    test_wrap();
    test_stale_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
